// File: rtl/riscv_icu_issue.sv
// riscv_icu_issue -- execute-stage sequencer for the multi-cycle mul/div
// lanes of the integer compute unit.
//
// Takes a decoded mul/div op from ID/EX and latches it with its operands.
// It then gives the compute unit a one-cycle start (ctrl enable bit) and
// holds stall high until the unit reports valid. The result is returned
// with a one-cycle done pulse.
//
// Optional feature (macro RISCV_ICU_DIVZERO_FAST_EN): a divide by zero is
// resolved locally from IDLE straight to DONE and never reaches the unit.
//
// Ports:
//   i_riscv_issue_clk / i_riscv_issue_rst    clock, async active-low reset
//   i_riscv_issue_valid                      EX holds a valid instruction
//   i_riscv_issue_mulctrl / _divctrl         {enable, op[2:0]} from decode
//   i_riscv_issue_funcsel                    output-mux select (00 mul, 01 div, 10 ALU)
//   i_riscv_issue_rs1data / _rs2data         operands
//   i_riscv_issue_flush                      kill the in-flight op
//   i_riscv_issue_icuvalid / _icuresult      compute unit result handshake
//   o_riscv_issue_mulctrl / _divctrl         control to compute unit
//   o_riscv_issue_funcsel                    output-mux select to compute unit
//   o_riscv_issue_alurs1data / _alurs2data   operands to compute unit
//   o_riscv_issue_stall                      freeze IF/ID/EX
//   o_riscv_issue_done                       one-cycle result-valid pulse
//   o_riscv_issue_result                     captured result
module riscv_icu_issue #(
    parameter int XLEN = 64
) (
    input  logic            i_riscv_issue_clk,
    input  logic            i_riscv_issue_rst,
    input  logic            i_riscv_issue_valid,
    input  logic [3:0]      i_riscv_issue_mulctrl,
    input  logic [3:0]      i_riscv_issue_divctrl,
    input  logic [1:0]      i_riscv_issue_funcsel,
    input  logic [XLEN-1:0] i_riscv_issue_rs1data,
    input  logic [XLEN-1:0] i_riscv_issue_rs2data,
    input  logic            i_riscv_issue_flush,
    input  logic            i_riscv_issue_icuvalid,
    input  logic [XLEN-1:0] i_riscv_issue_icuresult,
    output logic [3:0]      o_riscv_issue_mulctrl,
    output logic [3:0]      o_riscv_issue_divctrl,
    output logic [1:0]      o_riscv_issue_funcsel,
    output logic [XLEN-1:0] o_riscv_issue_alurs1data,
    output logic [XLEN-1:0] o_riscv_issue_alurs2data,
    output logic            o_riscv_issue_stall,
    output logic            o_riscv_issue_done,
    output logic [XLEN-1:0] o_riscv_issue_result
);

    typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DRAIN, S_DONE} state_t;

    state_t            state;
    logic [XLEN-1:0]   rs1_q, rs2_q, result_q;
    logic [3:0]        mul_q, div_q;
    logic [1:0]        func_q;

    logic              start, go;
    logic [3:0]        mul_in, div_in;
    logic              fast;
    logic [XLEN-1:0]   fast_result;

    assign start  = i_riscv_issue_valid & (i_riscv_issue_mulctrl[3] | i_riscv_issue_divctrl[3]);
    assign go     = start & ~i_riscv_issue_flush;
    // Only the enabled unit's control is latched; mul takes precedence if
    // decode ever raises both enables.
    assign mul_in = i_riscv_issue_mulctrl[3] ? i_riscv_issue_mulctrl : 4'b0;
    assign div_in = (i_riscv_issue_divctrl[3] & ~i_riscv_issue_mulctrl[3]) ? i_riscv_issue_divctrl : 4'b0;

`ifdef RISCV_ICU_DIVZERO_FAST_EN
    // Zero-divisor results follow the RISC-V rules: quotient all ones,
    // remainder equals the dividend (sign-extended 32-bit for W forms).
    logic div_w, div_rem, div_zero;
    assign div_w    = i_riscv_issue_divctrl[2];
    assign div_rem  = i_riscv_issue_divctrl[1];
    assign div_zero = div_w ? (i_riscv_issue_rs2data[31:0] == 32'b0)
                            : (i_riscv_issue_rs2data == '0);
    assign fast     = go & div_in[3] & div_zero;
    always_comb begin
        fast_result = '1;
        if (div_rem)
            fast_result = div_w ? {{(XLEN-32){i_riscv_issue_rs1data[31]}}, i_riscv_issue_rs1data[31:0]}
                                : i_riscv_issue_rs1data;
    end
`else
    assign fast        = 1'b0;
    assign fast_result = '0;
`endif

    always_ff @(posedge i_riscv_issue_clk or negedge i_riscv_issue_rst) begin
        if (!i_riscv_issue_rst) begin
            state    <= S_IDLE;
            rs1_q    <= '0;
            rs2_q    <= '0;
            result_q <= '0;
            mul_q    <= '0;
            div_q    <= '0;
            func_q   <= '0;
        end else begin
            case (state)
                S_IDLE: if (go) begin
                    rs1_q  <= i_riscv_issue_rs1data;
                    rs2_q  <= i_riscv_issue_rs2data;
                    mul_q  <= mul_in;
                    func_q <= i_riscv_issue_funcsel;
                    if (fast) begin
                        // Enable never reaches the unit for a locally resolved op.
                        div_q    <= '0;
                        result_q <= fast_result;
                        state    <= S_DONE;
                    end else begin
                        div_q <= div_in;
                        state <= S_LAUNCH;
                    end
                end
                S_LAUNCH, S_WAIT: begin
                    // A flush abandons the op, but the unit is still busy.
                    // DRAIN waits for it unless it finishes this same cycle.
                    if (i_riscv_issue_flush)
                        state <= i_riscv_issue_icuvalid ? S_IDLE : S_DRAIN;
                    else if (i_riscv_issue_icuvalid) begin
                        result_q <= i_riscv_issue_icuresult;
                        state    <= S_DONE;
                    end else
                        state <= S_WAIT;
                end
                S_DRAIN: if (i_riscv_issue_icuvalid) state <= S_IDLE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        o_riscv_issue_mulctrl    = 4'b0;
        o_riscv_issue_divctrl    = 4'b0;
        o_riscv_issue_funcsel    = func_q;
        o_riscv_issue_alurs1data = rs1_q;
        o_riscv_issue_alurs2data = rs2_q;
        case (state)
            S_IDLE: begin
                o_riscv_issue_funcsel    = i_riscv_issue_funcsel;
                o_riscv_issue_alurs1data = i_riscv_issue_rs1data;
                o_riscv_issue_alurs2data = i_riscv_issue_rs2data;
            end
            S_LAUNCH: begin
                o_riscv_issue_mulctrl = mul_q;
                o_riscv_issue_divctrl = div_q;
            end
            S_WAIT, S_DRAIN: begin
                // The op code stays visible while the enable bit drops.
                o_riscv_issue_mulctrl = {1'b0, mul_q[2:0]};
                o_riscv_issue_divctrl = {1'b0, div_q[2:0]};
            end
            default: ;
        endcase
    end

    assign o_riscv_issue_stall  = ((state == S_IDLE) & go) | (state == S_LAUNCH) |
                                  (state == S_WAIT) | (state == S_DRAIN);
    assign o_riscv_issue_done   = (state == S_DONE);
    assign o_riscv_issue_result = result_q;

endmodule

// File: tb/tb_riscv_icu_issue.sv
// tb_riscv_icu_issue -- directed + randomized bench for riscv_icu_issue.
// The bench doubles as the compute unit. It returns the architecturally
// correct mul/div result only on the icuvalid cycle and garbage at all
// other times.
module tb_riscv_icu_issue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid, flush, icuvalid;
    logic [3:0]  mulctrl, divctrl;
    logic [1:0]  funcsel;
    logic [63:0] rs1, rs2, icuresult;
    logic [3:0]  o_mulctrl, o_divctrl;
    logic [1:0]  o_funcsel;
    logic [63:0] o_rs1, o_rs2, o_result;
    logic        o_stall, o_done;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_result;

    always #5 clk = ~clk;

    riscv_icu_issue #(.XLEN(64)) dut (
        .i_riscv_issue_clk        (clk),
        .i_riscv_issue_rst        (rst_n),
        .i_riscv_issue_valid      (valid),
        .i_riscv_issue_mulctrl    (mulctrl),
        .i_riscv_issue_divctrl    (divctrl),
        .i_riscv_issue_funcsel    (funcsel),
        .i_riscv_issue_rs1data    (rs1),
        .i_riscv_issue_rs2data    (rs2),
        .i_riscv_issue_flush      (flush),
        .i_riscv_issue_icuvalid   (icuvalid),
        .i_riscv_issue_icuresult  (icuresult),
        .o_riscv_issue_mulctrl    (o_mulctrl),
        .o_riscv_issue_divctrl    (o_divctrl),
        .o_riscv_issue_funcsel    (o_funcsel),
        .o_riscv_issue_alurs1data (o_rs1),
        .o_riscv_issue_alurs2data (o_rs2),
        .o_riscv_issue_stall      (o_stall),
        .o_riscv_issue_done       (o_done),
        .o_riscv_issue_result     (o_result)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // Architectural RISC-V M-extension result.
    function automatic logic [63:0] ref_op(input logic [3:0] mc, input logic [3:0] dc,
                                           input logic [63:0] a, input logic [63:0] b);
        logic [127:0] p;
        logic [31:0]  r32;
        logic         ovf64, ovf32;
        ovf64 = (a == 64'h8000_0000_0000_0000) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
        ovf32 = (a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF);
        if (mc[3]) begin
            case (mc[2:0])
                3'd0: begin p = {64'b0, a} * {64'b0, b}; return p[63:0]; end
                3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
                3'd2: begin p = {{64{a[63]}}, a} * {64'b0, b}; return p[127:64]; end
                3'd3: begin p = {64'b0, a} * {64'b0, b}; return p[127:64]; end
                3'd4: begin r32 = a[31:0] * b[31:0]; return sext32(r32); end
                default: return 64'b0;
            endcase
        end
        case (dc[2:0])
            3'd0: begin
                if (b == 0) return '1;
                if (ovf64) return a;
                return $signed(a) / $signed(b);
            end
            3'd1: return (b == 0) ? '1 : a / b;
            3'd2: begin
                if (b == 0) return a;
                if (ovf64) return 64'b0;
                return $signed(a) % $signed(b);
            end
            3'd3: return (b == 0) ? a : a % b;
            3'd4: begin
                if (b[31:0] == 0) return '1;
                if (ovf32) return sext32(a[31:0]);
                r32 = $signed(a[31:0]) / $signed(b[31:0]);
                return sext32(r32);
            end
            3'd5: begin
                if (b[31:0] == 0) return '1;
                r32 = a[31:0] / b[31:0];
                return sext32(r32);
            end
            3'd6: begin
                if (b[31:0] == 0) return sext32(a[31:0]);
                if (ovf32) return 64'b0;
                r32 = $signed(a[31:0]) % $signed(b[31:0]);
                return sext32(r32);
            end
            default: begin
                if (b[31:0] == 0) return sext32(a[31:0]);
                r32 = a[31:0] % b[31:0];
                return sext32(r32);
            end
        endcase
    endfunction

    function automatic bit is_fast(input logic [3:0] mc, input logic [3:0] dc, input logic [63:0] b);
        bit f;
        f = 1'b0;
`ifdef RISCV_ICU_DIVZERO_FAST_EN
        f = !mc[3] && dc[3] && (dc[2] ? (b[31:0] == 32'b0) : (b == 64'b0));
`endif
        return f;
    endfunction

    // One full instruction. The unit answers lat cycles after LAUNCH.
    // flush_at < 0 means no flush, otherwise flush is pulsed in that
    // cycle (cycle 0 = op presented).
    task automatic run_op(input logic [3:0] mc, input logic [3:0] dc, input logic [1:0] fs,
                          input logic [63:0] a, input logic [63:0] b,
                          input int lat, input int flush_at, input string tag);
        logic [63:0] ref_v;
        bit          fast, saw_done, hold_ok;
        int          stall_cnt, done_cnt, mul_en, div_en, last;
        int          exp_stall, exp_done, exp_mul, exp_div;
        ref_v     = ref_op(mc, dc, a, b);
        fast      = is_fast(mc, dc, b);
        saw_done  = 0;
        hold_ok   = 1;
        stall_cnt = 0; done_cnt = 0; mul_en = 0; div_en = 0;
        last      = (flush_at >= 0) ? lat + 3 : 40;
        valid = 1'b1; mulctrl = mc; divctrl = dc; funcsel = fs; rs1 = a; rs2 = b;
        for (int cyc = 0; cyc <= last; cyc++) begin
            if (cyc > 0) begin
                rs1 = {$urandom, $urandom};
                rs2 = {$urandom, $urandom};
            end
            icuvalid  = !fast && (cyc == 1 + lat);
            icuresult = icuvalid ? ref_v : {$urandom, $urandom};
            flush     = (cyc == flush_at);
            if (flush_at >= 0 && cyc > flush_at) begin
                valid = 1'b0; mulctrl = 4'b0; divctrl = 4'b0;
            end
            @(negedge clk);
            if (o_stall) stall_cnt++;
            if (o_done) begin done_cnt++; saw_done = 1; end
            if (o_mulctrl[3]) mul_en++;
            if (o_divctrl[3]) div_en++;
            if (cyc > 0 && o_stall && (o_rs1 !== a || o_rs2 !== b || o_funcsel !== fs))
                hold_ok = 0;
            @(posedge clk); #1;
            if (saw_done) break;
        end
        valid = 1'b0; mulctrl = 4'b0; divctrl = 4'b0; flush = 1'b0; icuvalid = 1'b0;
        exp_mul = mc[3] ? 1 : 0;
        exp_div = (!mc[3] && dc[3]) ? 1 : 0;
        if (fast) begin
            exp_stall = 1; exp_done = 1; exp_mul = 0; exp_div = 0;
        end else begin
            exp_stall = lat + 2;
            exp_done  = (flush_at >= 0) ? 0 : 1;
        end
        if (exp_done == 1) exp_result = ref_v;
        @(negedge clk);
        check({tag, "_stall_cycles"}, 64'(stall_cnt), 64'(exp_stall));
        check({tag, "_done_pulses"},  64'(done_cnt),  64'(exp_done));
        check({tag, "_mul_enable"},   64'(mul_en),    64'(exp_mul));
        check({tag, "_div_enable"},   64'(div_en),    64'(exp_div));
        check({tag, "_operand_hold"}, 64'(hold_ok),   64'd1);
        check({tag, "_result"},       o_result,       exp_result);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [63:0] a, b;
        logic [3:0]  mc, dc;
        int          lat, fl;

        // Reset state with IDLE pass-through.
        valid = 0; flush = 0; icuvalid = 0; mulctrl = 0; divctrl = 0;
        funcsel = 2'b10; rs1 = 64'h1234_5678_9ABC_DEF0; rs2 = 64'h0FED_CBA9_8765_4321;
        icuresult = 0; exp_result = 0;
        #2;
        check("rst_stall",   64'(o_stall),   64'd0);
        check("rst_done",    64'(o_done),    64'd0);
        check("rst_result",  o_result,       64'd0);
        check("rst_mulctrl", 64'(o_mulctrl), 64'd0);
        check("rst_divctrl", 64'(o_divctrl), 64'd0);
        check("rst_rs1",     o_rs1,          rs1);
        check("rst_funcsel", 64'(o_funcsel), 64'(funcsel));
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // ALU op: op bits present but no enables.
        valid = 1; funcsel = 2'b10; mulctrl = 4'b0001; divctrl = 4'b0010;
        rs1 = 64'hAAAA_0000_5555_1111; rs2 = 64'h0000_FFFF_0000_FFFF;
        @(negedge clk);
        check("alu_stall",   64'(o_stall),   64'd0);
        check("alu_mulctrl", 64'(o_mulctrl), 64'd0);
        check("alu_divctrl", 64'(o_divctrl), 64'd0);
        check("alu_rs1",     o_rs1,          rs1);
        check("alu_rs2",     o_rs2,          rs2);
        check("alu_funcsel", 64'(o_funcsel), 64'd2);
        @(posedge clk); #1;
        rs1 = 64'd99;
        #1 check("alu_rs1_comb", o_rs1, 64'd99);
        valid = 0; mulctrl = 0; divctrl = 0;

        // Flush in IDLE suppresses the start.
        valid = 1; mulctrl = 4'b1000; funcsel = 2'b00; flush = 1;
        @(negedge clk);
        check("idle_flush_stall", 64'(o_stall), 64'd0);
        @(posedge clk); #1;
        valid = 0; mulctrl = 0; flush = 0;
        @(negedge clk);
        check("idle_flush_nolaunch", 64'(o_mulctrl), 64'd0);
        check("idle_flush_nodone",   64'(o_done),    64'd0);
        @(posedge clk); #1;

        // MUL 7 * -3, unit answers 3 cycles after LAUNCH.
        run_op(4'b1000, 4'b0000, 2'b00, 64'd7, -64'd3, 3, -1, "mul");
        check("mul_const", o_result, 64'hFFFF_FFFF_FFFF_FFEB);

        // icuvalid while IDLE is ignored.
        icuvalid = 1; icuresult = 64'hDEAD_BEEF_DEAD_BEEF;
        @(negedge clk);
        check("idle_icuvalid_done", 64'(o_done), 64'd0);
        @(posedge clk); #1;
        icuvalid = 0;
        @(negedge clk);
        check("idle_icuvalid_result", o_result, exp_result);
        @(posedge clk); #1;

        // DIV 100/7, flushed in WAIT, unit answers 4 cycles after flush.
        run_op(4'b0000, 4'b1000, 2'b01, 64'd100, 64'd7, 5, 2, "div_flush");
        // Flush in LAUNCH with the unit answering in the same cycle.
        run_op(4'b0000, 4'b1010, 2'b01, 64'd100, 64'd7, 0, 1, "rem_flush_launch");

        // Back-to-back DIVU then MULHU, minimum-latency second op.
        run_op(4'b0000, 4'b1001, 2'b01, 64'hFFFF_FFFF_FFFF_FFF0, 64'd3, 2, -1, "divu_b2b");
        run_op(4'b1011, 4'b0000, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, -1, "mulhu_b2b");

        // REMW by zero: local fast path if enabled, else the normal path.
        run_op(4'b0000, 4'b1110, 2'b01, 64'h0000_0001_8000_0000, 64'd0, 3, -1, "remw_zero");
        check("remw_zero_const", o_result, 64'hFFFF_FFFF_8000_0000);

        // Both enables: mul wins.
        run_op(4'b1000, 4'b1000, 2'b00, 64'd6, 64'd9, 1, -1, "both_en");

        // Reset asserted while in WAIT.
        valid = 1; mulctrl = 4'b1000; funcsel = 2'b00; rs1 = 64'd5; rs2 = 64'd5;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2;
        rst_n = 0; valid = 0; mulctrl = 0;
        #1;
        check("midrst_stall",   64'(o_stall),   64'd0);
        check("midrst_done",    64'(o_done),    64'd0);
        check("midrst_mulctrl", 64'(o_mulctrl), 64'd0);
        check("midrst_result",  o_result,       64'd0);
        exp_result = 64'd0;
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        run_op(4'b1000, 4'b0000, 2'b00, 64'd12, 64'd12, 1, -1, "post_rst");

        // Randomized ops.
        for (int i = 0; i < 40; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: b = 64'd0;
                1: b[31:0] = 32'd0;
                default: ;
            endcase
            if ($urandom_range(0, 1) == 1) begin
                mc = {1'b1, 3'($urandom_range(0, 4))}; dc = 4'b0;
            end else begin
                mc = 4'b0; dc = {1'b1, 3'($urandom_range(0, 7))};
            end
            lat = $urandom_range(0, 6);
            fl  = -1;
            if (!is_fast(mc, dc, b) && $urandom_range(0, 4) == 0)
                fl = $urandom_range(1, 1 + lat);
            run_op(mc, dc, mc[3] ? 2'b00 : 2'b01, a, b, lat, fl, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
